// File: rtl/vga_clk_mon.sv
// Monitors an asynchronous clock in the clk domain: measures period and high time,
// checks the period against a window, and reports lock, stop and range errors.
module vga_clk_mon #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             running,
  output logic             locked,
  output logic             err_range,
  output logic             err_stop
);

  localparam int LK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LK_W-1:0]  LK_FULL = LK_W'(LOCK_CNT);
  localparam logic [LK_W-1:0]  LK_PRE  = LK_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_MEASURE,
    S_STOPPED
  } state_t;

  state_t r_state, w_next;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt, r_hcnt;
  logic [CNT_W-1:0] r_period, r_high;
  logic             r_vld, r_locked, r_err_range, r_err_stop;
  logic [LK_W-1:0]  r_lock_cnt;

  logic             w_rise, w_report, w_timeout, w_in_range;
  logic [CNT_W-1:0] w_meas;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign w_rise     = r_s2 & ~r_s3;
  assign w_meas     = sat_inc(r_cnt);
  assign w_in_range = (w_meas >= exp_min) && (w_meas <= exp_max);
  assign w_report   = en && (r_state == S_MEASURE) && w_rise;
  assign w_timeout  = en && (r_state == S_MEASURE) && !w_rise && (r_cnt == TO_LAST);

  // Input synchronizer plus edge-detect history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= mon_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_SYNC;
        S_SYNC:    if (w_rise) w_next = S_MEASURE;
        S_MEASURE: if (w_timeout) w_next = S_STOPPED;
        S_STOPPED: if (w_rise) w_next = S_MEASURE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Interval counters: restart on every rise, high counter only advances while high
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= '0;
      r_hcnt <= CNT_W'(1);
    end else begin
      r_cnt <= sat_inc(r_cnt);
      if (r_s2) r_hcnt <= sat_inc(r_hcnt);
    end
  end

  // Report stage: one registered cycle after the rise that closes an interval
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
      r_high   <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_vld <= w_report;
      if (w_report) begin
        r_period <= w_meas;
        r_high   <= r_hcnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en || w_timeout || r_state != S_MEASURE) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_report) begin
      if (w_in_range) begin
        if (r_lock_cnt != LK_FULL) r_lock_cnt <= r_lock_cnt + 1'b1;
        r_locked <= (r_lock_cnt >= LK_PRE);
      end else begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_range <= 1'b0;
      r_err_stop  <= 1'b0;
    end else begin
      r_err_range <= (r_err_range & ~clr_err) | (w_report & ~w_in_range);
      r_err_stop  <= (r_err_stop & ~clr_err) | w_timeout;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign period_vld = r_vld;
  assign running    = (r_state == S_MEASURE);
  assign locked     = r_locked;
  assign err_range  = r_err_range;
  assign err_stop   = r_err_stop;

endmodule

// File: tb/tb_vga_clk_mon.sv
// Bench for vga_clk_mon: two instances (16-bit/TIMEOUT 50 and 4-bit/TIMEOUT 15)
// compared every cycle against a timestamp-based reference model.
module tb_vga_clk_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mon_clk, clr_err;
  logic [15:0] exp_min, exp_max;

  logic [15:0] period0, high0;
  logic        vld0, run0, lock0, er0, es0;
  logic [3:0]  period1, high1;
  logic        vld1, run1, lock1, er1, es1;

  vga_clk_mon #(.CNT_W(16), .TIMEOUT(50), .LOCK_CNT(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .mon_clk(mon_clk),
    .exp_min(exp_min), .exp_max(exp_max), .clr_err(clr_err),
    .period(period0), .high_time(high0), .period_vld(vld0), .running(run0),
    .locked(lock0), .err_range(er0), .err_stop(es0));

  vga_clk_mon #(.CNT_W(4), .TIMEOUT(15), .LOCK_CNT(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .mon_clk(mon_clk),
    .exp_min(exp_min[3:0]), .exp_max(exp_max[3:0]), .clr_err(clr_err),
    .period(period1), .high_time(high1), .period_vld(vld1), .running(run1),
    .locked(lock1), .err_range(er1), .err_stop(es1));

  int n_pass = 0;
  int n_total = 0;
  int k = 0;

  // mon_clk generator state
  int mon_run = 0, ph = 0, per = 8, hi = 4;

  // Reference model: mode 0 idle, 1 sync, 2 measure, 3 stopped
  int TO[2] = '{50, 15};
  int MX[2] = '{65535, 15};
  int m_mode[2], t_rise[2], t_fall[2], lockc[2];
  bit sy1[2], sy2[2], sy3[2];
  int e_per[2], e_high[2];
  bit e_vld[2], e_lock[2], e_er[2], e_es[2];

  task automatic model(input int i);
    bit rise, fall, set_r, set_s;
    int p, h, emn, emx;
    rise = sy2[i] && !sy3[i];
    fall = !sy2[i] && sy3[i];
    if (rst) begin
      m_mode[i] = 0; lockc[i] = 0; t_rise[i] = 0; t_fall[i] = -1;
      sy1[i] = 0; sy2[i] = 0; sy3[i] = 0;
      e_per[i] = 0; e_high[i] = 0;
      e_vld[i] = 0; e_lock[i] = 0; e_er[i] = 0; e_es[i] = 0;
      return;
    end
    set_r = 0; set_s = 0; e_vld[i] = 0;
    if (!en) begin
      m_mode[i] = 0; lockc[i] = 0; e_lock[i] = 0;
    end else begin
      case (m_mode[i])
        0: m_mode[i] = 1;
        1: if (rise) begin m_mode[i] = 2; t_rise[i] = k; t_fall[i] = -1; end
        2: begin
          if (rise) begin
            p = k - t_rise[i];
            h = (t_fall[i] < 0) ? p : t_fall[i] - t_rise[i];
            if (p > MX[i]) p = MX[i];
            if (h > MX[i]) h = MX[i];
            e_per[i] = p; e_high[i] = h; e_vld[i] = 1;
            emn = int'(exp_min) & MX[i];
            emx = int'(exp_max) & MX[i];
            if (p >= emn && p <= emx) begin
              if (lockc[i] < 4) lockc[i]++;
              e_lock[i] = (lockc[i] == 4);
            end else begin
              lockc[i] = 0; e_lock[i] = 0; set_r = 1;
            end
            t_rise[i] = k; t_fall[i] = -1;
          end else begin
            if (fall) t_fall[i] = k;
            if (k - t_rise[i] == TO[i]) begin
              m_mode[i] = 3; set_s = 1; lockc[i] = 0; e_lock[i] = 0;
            end
          end
        end
        default: if (rise) begin m_mode[i] = 2; t_rise[i] = k; t_fall[i] = -1; end
      endcase
    end
    e_er[i] = (e_er[i] && !clr_err) || set_r;
    e_es[i] = (e_es[i] && !clr_err) || set_s;
    sy3[i] = sy2[i]; sy2[i] = sy1[i]; sy1[i] = mon_clk;
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s[%0d] cycle %0d: got %0d expected %0d", tag, i, k, act, exp);
  endtask

  task automatic compare_all();
    chk("period",     0, {16'b0, period0}, e_per[0]);
    chk("high_time",  0, {16'b0, high0},   e_high[0]);
    chk("period_vld", 0, {31'b0, vld0},    {31'b0, e_vld[0]});
    chk("running",    0, {31'b0, run0},    {31'b0, m_mode[0] == 2});
    chk("locked",     0, {31'b0, lock0},   {31'b0, e_lock[0]});
    chk("err_range",  0, {31'b0, er0},     {31'b0, e_er[0]});
    chk("err_stop",   0, {31'b0, es0},     {31'b0, e_es[0]});
    chk("period",     1, {28'b0, period1}, e_per[1]);
    chk("high_time",  1, {28'b0, high1},   e_high[1]);
    chk("period_vld", 1, {31'b0, vld1},    {31'b0, e_vld[1]});
    chk("running",    1, {31'b0, run1},    {31'b0, m_mode[1] == 2});
    chk("locked",     1, {31'b0, lock1},   {31'b0, e_lock[1]});
    chk("err_range",  1, {31'b0, er1},     {31'b0, e_er[1]});
    chk("err_stop",   1, {31'b0, es1},     {31'b0, e_es[1]});
  endtask

  task automatic step();
    mon_clk = (mon_run != 0) && (ph < hi);
    if (mon_run != 0) ph = (ph + 1 == per) ? 0 : ph + 1;
    @(posedge clk);
    k++;
    model(0);
    model(1);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  // Finish the current period, hold low a few cycles, then start the new shape
  task automatic set_clk(input int new_per, input int new_hi);
    while (mon_run != 0 && ph != 0) step();
    mon_run = 0;
    run(3);
    per = new_per; hi = new_hi; ph = 0;
    mon_run = (new_per > 0) ? 1 : 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; mon_clk = 1'b0;
    exp_min = 16'd7; exp_max = 16'd9;
    run(3);
    chk("reset_period", 0, {16'b0, period0}, 32'd0);
    chk("reset_running", 0, {31'b0, run0}, 32'd0);

    // Nominal 80 ns clock inside the window
    rst = 1'b0; en = 1'b1;
    set_clk(8, 4);
    run(80);
    chk("lock_period", 0, {16'b0, period0}, 32'd8);
    chk("lock_high",   0, {16'b0, high0},   32'd4);
    chk("lock_locked", 0, {31'b0, lock0},   32'd1);
    chk("lock_noerr",  0, {31'b0, er0},     32'd0);

    // Window excludes the clock; sweep clr_err across the period so one pulse meets a report
    exp_min = 16'd10; exp_max = 16'd12;
    run(60);
    chk("range_err",  0, {31'b0, er0},   32'd1);
    chk("range_lock", 0, {31'b0, lock0}, 32'd0);
    for (int j = 0; j < 8; j++) begin
      clr_err = 1'b1; step(); clr_err = 1'b0; run(8);
    end

    // Lock, stop the clock, then restart it
    exp_min = 16'd7; exp_max = 16'd9;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    run(60);
    set_clk(0, 0);
    run(60);
    chk("stop_err",     0, {31'b0, es0},  32'd1);
    chk("stop_running", 0, {31'b0, run0}, 32'd0);
    set_clk(8, 4);
    run(60);
    chk("relock",        0, {31'b0, lock0},   32'd1);
    chk("relock_period", 0, {16'b0, period0}, 32'd8);

    // Drop enable for three cycles mid-period
    run(3);
    en = 1'b0;
    run(3);
    chk("en_low_lock",   0, {31'b0, lock0},   32'd0);
    chk("en_low_period", 0, {16'b0, period0}, 32'd8);
    en = 1'b1;
    run(40);

    // Randomized segments: clock shape, window, enable drops, clears
    for (int s = 0; s < 12; s++) begin
      int np, nh, nc;
      np = int'($urandom_range(4, 40));
      nh = int'($urandom_range(2, np - 2));
      if ($urandom_range(0, 5) == 0) set_clk(0, 0);
      else set_clk(np, nh);
      exp_min = 16'($urandom_range(0, 20));
      exp_max = 16'($urandom_range(0, 20));
      nc = int'($urandom_range(40, 150));
      for (int j = 0; j < nc; j++) begin
        en = ($urandom_range(0, 49) != 0);
        clr_err = ($urandom_range(0, 29) == 0);
        step();
      end
      en = 1'b1; clr_err = 1'b0;
    end

    // 300 ns clock: the 4-bit instance times out at 15 without wrapping
    exp_min = 16'd0; exp_max = 16'hFFFF;
    set_clk(30, 15);
    run(100);
    chk("slow_stop", 1, {31'b0, es1}, 32'd1);

    // Reset mid-period with flags set
    run(7);
    rst = 1'b1;
    step();
    chk("rst_err_stop",  1, {31'b0, es1},     32'd0);
    chk("rst_period",    0, {16'b0, period0}, 32'd0);
    chk("rst_err_range", 0, {31'b0, er0},     32'd0);
    rst = 1'b0;
    run(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_clk_mon.md
# vga_clk_mon

Synthesizable monitor for an externally generated clock (typically the VGA pixel clock from the bench clock generator or a PLL output). It samples `mon_clk` in the `clk` domain, measures its period and high time in `clk` cycles, checks the period against a programmable window, and reports lock, stop and out-of-range conditions. It is the checking end of the clock-generation path and is used both in benches and in silicon status registers.

## Interface
- `CNT_W`, 16, width of period/high-time counters and limit inputs
- `TIMEOUT`, 1000, `clk` cycles without a `mon_clk` rising edge before the clock is declared stopped; legal range 2..2^CNT_W-1
- `LOCK_CNT`, 4, consecutive in-range periods required to assert `locked`; must be ≥1

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  monitor enable; low forces IDLE
- `mon_clk`  in  1  monitored clock, asynchronous to `clk`
- `exp_min`  in  CNT_W  minimum legal period (cycles, inclusive)
- `exp_max`  in  CNT_W  maximum legal period (cycles, inclusive)
- `clr_err`  in  1  clears sticky error flags
- `period`  out  CNT_W  last measured period in `clk` cycles
- `high_time`  out  CNT_W  last measured high phase in `clk` cycles
- `period_vld`  out  1  one-cycle pulse, `period`/`high_time` updated
- `running`  out  1  edges are being seen (state MEASURE)
- `locked`  out  1  LOCK_CNT consecutive in-range periods
- `err_range`  out  1  sticky: a period fell outside [exp_min, exp_max]
- `err_stop`  out  1  sticky: timeout expired while measuring

## Operation
- Input path: 2-flop synchronizer `s1`,`s2`, history flop `s3`; `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- Constraint: `mon_clk` high and low phases each ≥2 `clk` cycles; behaviour undefined otherwise.
- `cnt`: cycles since last rise; loaded 0 on the `rise` cycle, +1 each other cycle, saturates at 2^CNT_W-1. `hcnt`: loaded 1 on `rise`, +1 while `s2` high, frozen after `fall`, saturates likewise.
- States:
  - IDLE: counters 0, `running`=0, `locked`=0. `en`=1 → SYNC.
  - SYNC: wait first `rise` (no measurement). `rise` → MEASURE, counters restart. No timeout in SYNC.
  - MEASURE: `running`=1. On `rise`: `period`<=`cnt`+1 (saturating), `high_time`<=`hcnt`, `period_vld`=1 next cycle, range check performed, counters restart. If `cnt` reaches TIMEOUT-1 with no `rise` → STOPPED, `err_stop` set.
  - STOPPED: `running`=0, `locked`=0. Next `rise` → MEASURE with counters restarted; the interval spanning the stop is never reported.
- `en`=0 in any state → IDLE next cycle; outputs `period`/`high_time` hold, sticky flags hold.
- Range check: in range iff `exp_min` ≤ period ≤ `exp_max` (unsigned). In range: lock counter +1, saturating at LOCK_CNT; `locked`=1 when it equals LOCK_CNT. Out of range: lock counter 0, `locked`=0, `err_range` set. `exp_min` > `exp_max` makes every period out of range.
- Sticky flags cleared by `clr_err`; same-cycle set and clear → set wins.

## Timing
- Reset: state IDLE, `period`=0, `high_time`=0, `period_vld`=0, `running`=0, `locked`=0, `err_range`=0, `err_stop`=0, synchronizer flops 0.
- `mon_clk` rising edge → `rise` 2–3 `clk` cycles later (synchronizer uncertainty ±1).
- `rise` cycle N → `period`, `high_time`, `period_vld`, `err_range`, `locked` all valid at cycle N+1 (single registered stage).
- Timeout: `err_stop` and `running`=0 one cycle after `cnt`==TIMEOUT-1.
- `en` low → IDLE: `running`/`locked` low next cycle; a `rise` in that same cycle is discarded.
- `rst` mid-measurement discards the partial interval; first report requires two rises after reset release plus `en`.

## Test plan
- `clk` 10 ns, `mon_clk` 80 ns 50 % duty, `exp_min`=7, `exp_max`=9: first `period_vld` after second edge, `period`=8, `high_time`=4; `locked`=1 on 4th report; no errors.
- Same clock, `exp_min`=10, `exp_max`=12: every report `err_range`=1, `locked` stays 0; pulse `clr_err` with edge in flight → flag re-sets on next report (set wins).
- Locked at 80 ns, stop `mon_clk` low, TIMEOUT=50: `err_stop`=1 and `running`=0 exactly 50 cycles after last `rise`; restart → first report after second new edge, `period`=8, `locked` re-acquired after 4.
- Drop `en` for 3 cycles mid-period: IDLE, `locked`=0, `period` holds 8; re-enable → SYNC, no report until two rises.
- CNT_W=4, `mon_clk` 300 ns period, TIMEOUT=15 disabled by holding period < timeout impossible → verify `cnt` saturation at 15 and `err_stop` at 15 cycles, no counter wrap.
- Assert `rst` mid-period with errors set: all outputs to reset values next cycle, sticky flags 0.
